// File: rtl/vdp_sprite_write_scheduler.sv
// Sprite register write scheduler: buffers CPU writes in a small FIFO and
// releases them as one-hot per-slot strobes, optionally only during vblank.
module vdp_sprite_write_scheduler #(
    parameter int N_SPRITES  = 8,
    parameter int SIDX_W     = 3,
    parameter int ROW_IDX_W  = 3,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sync_mode,
    input  logic                          vblank,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [SIDX_W+ROW_IDX_W:0]     req_addr,
    input  logic [DATA_W-1:0]             req_data,
    output logic [DATA_W-1:0]             wr_data,
    output logic [ROW_IDX_W-1:0]          wr_row_index,
    output logic [N_SPRITES-1:0]          xy_we,
    output logic [N_SPRITES-1:0]          row_we,
    output logic                          busy,
    output logic                          err_drop,
    input  logic                          err_clr
);

    localparam int ADDR_W  = SIDX_W + 1 + ROW_IDX_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VB,
        ISSUE
    } state_t;

    state_t                state, state_next;
    logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count, count_next;
    logic                  accept, drop, push, pop;
    logic [SIDX_W-1:0]     req_idx;
    logic [SIDX_W-1:0]     head_idx;
    logic                  head_is_row;
    logic [ROW_IDX_W-1:0]  head_row;
    logic [DATA_W-1:0]     head_data;
    logic [N_SPRITES-1:0]  head_onehot;

    // Requests aimed at a non-existent slot still complete the handshake but never enter the FIFO
    assign req_idx = req_addr[ADDR_W-1 -: SIDX_W];
    assign accept  = req_valid && req_ready;
    assign drop    = accept && (32'(req_idx) >= N_SPRITES);
    assign push    = accept && !drop;
    assign pop     = (state == ISSUE) && (count != '0);

    assign {head_idx, head_is_row, head_row, head_data} = fifo_mem[rd_ptr];
    assign busy = (count != '0) || (|xy_we) || (|row_we);

    // Decode the head entry's sprite index into a per-slot select
    always_comb begin
        head_onehot = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            head_onehot[i] = (head_idx == SIDX_W'(i));
        end
    end

    // Next occupancy; push and pop together leave it unchanged
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (!push && pop) begin
            count_next = count - 1'b1;
        end
    end

    // FIFO storage; contents need no reset because occupancy guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_addr, req_data};
        end
    end

    // Pointers, occupancy and the registered ready (no same-cycle bypass when full)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_next;
            req_ready <= (count_next != (PTR_W+1)'(FIFO_DEPTH));
        end
    end

    // Sticky drop flag; a new drop wins over a clear in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_drop <= 1'b0;
        end else if (drop) begin
            err_drop <= 1'b1;
        end else if (err_clr) begin
            err_drop <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue gating: in sync mode a low vblank parks the drain, letting an in-progress pop finish
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = (!sync_mode || vblank) ? ISSUE : WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (vblank || !sync_mode) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (count_next == '0) begin
                    state_next = IDLE;
                end else if (sync_mode && !vblank) begin
                    state_next = WAIT_VB;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered strobes and shared write bus; strobes last exactly one clock per pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xy_we        <= '0;
            row_we       <= '0;
            wr_data      <= '0;
            wr_row_index <= '0;
        end else if (pop) begin
            xy_we        <= head_is_row ? '0 : head_onehot;
            row_we       <= head_is_row ? head_onehot : '0;
            wr_data      <= head_data;
            wr_row_index <= head_row;
        end else begin
            xy_we  <= '0;
            row_we <= '0;
        end
    end

endmodule

// File: tb/tb_vdp_sprite_write_scheduler.sv
// Self-checking bench for vdp_sprite_write_scheduler: a queue-based scoreboard
// follows every accepted write, plus directed scenarios with literal expectations.
module tb_vdp_sprite_write_scheduler;

    localparam int N      = 6;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sync_mode = 1'b0;
    logic        vblank = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic [31:0] wr_data;
    logic [2:0]  wr_row_index;
    logic [N-1:0] xy_we;
    logic [N-1:0] row_we;
    logic        busy;
    logic        err_drop;
    logic        err_clr = 1'b0;

    typedef struct {
        int          slot;
        bit          is_row;
        int          row;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    bit  err_exp = 1'b0;
    int  strobe_count = 0;
    int  cyc = 0;
    int  total_checks = 0;
    int  passed_checks = 0;

    vdp_sprite_write_scheduler #(
        .N_SPRITES(N), .SIDX_W(3), .ROW_IDX_W(3), .DATA_W(32), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .sync_mode(sync_mode), .vblank(vblank),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .wr_data(wr_data), .wr_row_index(wr_row_index),
        .xy_we(xy_we), .row_we(row_we), .busy(busy), .err_drop(err_drop),
        .err_clr(err_clr)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter for throughput measurements
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            passed_checks++;
        end
    endtask

    // Offer one write and hold it until the handshake completes; leaves req_valid high
    task automatic applyStimulus(input int slot, input bit is_row, input int row, input logic [31:0] data);
        bit done = 1'b0;
        req_valid = 1'b1;
        req_addr  = {slot[2:0], is_row, row[2:0]};
        req_data  = data;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) checkOutput("handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: what was accepted, in order, and the expected sticky error
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            err_exp = 1'b0;
        end else begin
            bit dropped;
            dropped = 1'b0;
            if (req_valid && req_ready) begin
                wr_t e;
                e.slot   = int'(req_addr) / 16;
                e.is_row = ((int'(req_addr) / 8) % 2) == 1;
                e.row    = int'(req_addr) % 8;
                e.data   = req_data;
                if (e.slot >= N) dropped = 1'b1;
                else exp_q.push_back(e);
            end
            if (dropped) err_exp = 1'b1;
            else if (err_clr) err_exp = 1'b0;
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (!reset) begin
            logic [N-1:0] strobe;
            logic [N-1:0] sel;
            wr_t e;
            strobe = xy_we | row_we;
            checkOutput("strobe_onehot", 64'($countones(strobe) <= 1), 64'd1);
            if (strobe != '0) begin
                strobe_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_strobe", 64'(strobe), 64'd0);
                end else begin
                    e   = exp_q.pop_front();
                    sel = N'(1) << e.slot;
                    checkOutput("xy_we", 64'(xy_we), e.is_row ? 64'd0 : 64'(sel));
                    checkOutput("row_we", 64'(row_we), e.is_row ? 64'(sel) : 64'd0);
                    checkOutput("wr_data", 64'(wr_data), 64'(e.data));
                    checkOutput("wr_row_index", 64'(wr_row_index), 64'(e.row));
                end
            end
            checkOutput("busy", 64'(busy), 64'((exp_q.size() != 0) || (strobe != '0)));
            checkOutput("req_ready", 64'(req_ready), 64'(exp_q.size() < DEPTH));
            checkOutput("err_drop", 64'(err_drop), 64'(err_exp));
        end
    end

    // Directed scenarios
    initial begin
        int base;
        int c0;

        #12;
        checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_strobes", 64'({xy_we, row_we}), 64'd0);
        checkOutput("reset_err_drop", 64'(err_drop), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(2);

        // 1) single XY write, non-sync: strobe two cycles after the push edge
        applyStimulus(2, 1'b0, 0, 32'h8001_0010);
        req_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("t1_no_strobe_yet", 64'(xy_we), 64'd0);
        @(posedge clk); #1;
        checkOutput("t1_xy_we", 64'(xy_we), 64'b000100);
        checkOutput("t1_wr_data", 64'(wr_data), 64'h8001_0010);
        @(posedge clk); #1;
        checkOutput("t1_one_clk", 64'(xy_we), 64'd0);
        idle_cycles(2);

        // 2) sync mode, blanking low: four row writes held, then drained back-to-back
        sync_mode = 1'b1;
        vblank    = 1'b0;
        base = strobe_count;
        for (int r = 0; r < 4; r++) applyStimulus(5, 1'b1, r, 32'h5500_0000 + r);
        req_valid = 1'b0;
        checkOutput("t2_full_not_ready", 64'(req_ready), 64'd0);
        idle_cycles(5);
        checkOutput("t2_held", 64'(strobe_count - base), 64'd0);
        vblank = 1'b1;
        @(posedge clk);
        @(posedge clk);
        for (int r = 0; r < 4; r++) begin
            #1;
            checkOutput("t2_row_we", 64'(row_we), 64'b100000);
            checkOutput("t2_row_index", 64'(wr_row_index), 64'(r));
            @(posedge clk);
        end
        #1;
        checkOutput("t2_done", 64'(row_we), 64'd0);
        idle_cycles(2);

        // 3) blanking ends mid-drain: partial issue, remainder on the next blanking
        vblank = 1'b0;
        for (int r = 0; r < 4; r++) applyStimulus(1, 1'b0, r, 32'hA000_0000 + r);
        req_valid = 1'b0;
        base = strobe_count;
        vblank = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vblank = 1'b0;
        idle_cycles(6);
        checkOutput("t3_partial", 64'(((strobe_count - base) >= 2) && ((strobe_count - base) <= 3)), 64'd1);
        checkOutput("t3_still_busy", 64'(busy), 64'd1);
        vblank = 1'b1;
        idle_cycles(8);
        checkOutput("t3_all_issued", 64'(strobe_count - base), 64'd4);

        // 4) out-of-range sprite index is dropped and flagged
        sync_mode = 1'b0;
        base = strobe_count;
        applyStimulus(7, 1'b0, 0, 32'hDEAD_BEEF);
        req_valid = 1'b0;
        checkOutput("t4_err_set", 64'(err_drop), 64'd1);
        idle_cycles(3);
        checkOutput("t4_no_strobe", 64'(strobe_count - base), 64'd0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        checkOutput("t4_err_cleared", 64'(err_drop), 64'd0);
        err_clr = 1'b1;
        applyStimulus(6, 1'b1, 2, 32'h1234_5678);
        req_valid = 1'b0;
        err_clr = 1'b0;
        checkOutput("t4_drop_beats_clr", 64'(err_drop), 64'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;

        // 5) back-to-back writes at full rate
        base = strobe_count;
        c0 = cyc;
        for (int i = 0; i < 8; i++) applyStimulus(i % N, i[0], i, 32'hC000_0000 + i);
        req_valid = 1'b0;
        checkOutput("t5_one_per_clk", 64'(cyc - c0), 64'd8);
        idle_cycles(6);
        checkOutput("t5_all_issued", 64'(strobe_count - base), 64'd8);

        // 6) reset with queued entries discards them
        sync_mode = 1'b1;
        vblank    = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(3, 1'b0, i, 32'hEE00_0000 + i);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("t6_strobes", 64'({xy_we, row_we}), 64'd0);
        checkOutput("t6_busy", 64'(busy), 64'd0);
        checkOutput("t6_ready", 64'(req_ready), 64'd1);
        idle_cycles(2);
        reset = 1'b0;
        sync_mode = 1'b0;
        base = strobe_count;
        idle_cycles(5);
        checkOutput("t6_discarded", 64'(strobe_count - base), 64'd0);
        applyStimulus(4, 1'b1, 7, 32'h0BAD_F00D);
        req_valid = 1'b0;
        idle_cycles(5);
        checkOutput("t6_after_reset", 64'(strobe_count - base), 64'd1);
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

    // Watchdog so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
